// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared defaults, stage derivation and opcodes for the pipelined adder
package pipelined_adder_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 16;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
  function automatic int stages(input int width, input int chunk);
    return width / chunk;
  endfunction
endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit adder slice with carry in/out
module adder_chunk import pipelined_adder_pkg::*; #(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract resolved CHUNK bits per stage, with valid/ready flow control
module pipelined_adder import pipelined_adder_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int STAGES = stages(WIDTH, CHUNK);
  logic stall;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k * CHUNK;
    logic [IW-1:0] x_i, y_i;
    logic c_i, v_i, co;
    logic [CHUNK-1:0] cs;
    logic [(k+1)*CHUNK-1:0] s_d, s_q;
    logic c_d, c_q, v_d, v_q;
    if (k == 0) begin : g_head
      assign x_i = a;
      assign y_i = (sub == SUB) ? ~b : b;
      assign c_i = (sub == ADD) ? c_in : ~c_in;
      assign v_i = in_valid;
      always_comb s_d = cs;
    end else begin : g_link
      assign x_i = g_st[k-1].g_skew.x_q;
      assign y_i = g_st[k-1].g_skew.y_q;
      assign c_i = g_st[k-1].c_q;
      assign v_i = g_st[k-1].v_q;
      always_comb s_d = {cs, g_st[k-1].s_q};
    end
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x(x_i[CHUNK-1:0]), .y(y_i[CHUNK-1:0]), .cin(c_i), .s(cs), .cout(co)
    );
    always_comb begin
      c_d = co;
      v_d = v_i;
    end
    always_ff @(posedge clk)
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (!stall) begin
        s_q <= s_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    if (k < STAGES - 1) begin : g_skew
      logic [IW-CHUNK-1:0] x_d, x_q, y_d, y_q;
      always_comb begin
        x_d = x_i[IW-1:CHUNK];
        y_d = y_i[IW-1:CHUNK];
      end
      always_ff @(posedge clk)
        if (rst) begin
          x_q <= '0;
          y_q <= '0;
        end else if (!stall) begin
          x_q <= x_d;
          y_q <= y_d;
        end
    end else begin : g_tail
      // top chunk carries both operand MSBs, so signed overflow is resolved here
      logic ov_d, ov_q;
      always_comb ov_d = (x_i[CHUNK-1] == y_i[CHUNK-1]) && (cs[CHUNK-1] != x_i[CHUNK-1]);
      always_ff @(posedge clk)
        if (rst) ov_q <= 1'b0;
        else if (!stall) ov_q <= ov_d;
      assign out_valid = v_q && !rst;
      assign sum = rst ? '0 : s_q;
      assign c_out = rst ? 1'b0 : c_q;
      assign overflow = rst ? 1'b0 : ov_q;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of the 64/16 and 32/8 adder pipelines
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic iv64, ir64, ov64, or64, cin64, sub64, c64, o64;
  logic [63:0] a64, b64, s64;
  logic iv32, ir32, ov32, or32, cin32, sub32, c32, o32;
  logic [31:0] a32, b32, s32;
  int errors = 0, checks = 0;
  int sent, got;
  bit prev;
  logic [65:0] held, e66;
  logic [65:0] exq[$];
  logic [33:0] e34;
  logic [33:0] q32[$];

  pipelined_adder dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .c_in(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(s64),
    .c_out(c64), .overflow(o64)
  );
  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .c_in(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .c_out(c32), .overflow(o32)
  );

  function automatic logic [65:0] m64(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb);
    logic [63:0] be;
    logic [64:0] r;
    be = sb ? ~b : b;
    r = {1'b0, a} + {1'b0, be} + {64'd0, sb ? ~ci : ci};
    return {(a[63] == be[63]) && (r[63] != a[63]), r};
  endfunction

  function automatic logic [33:0] m32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
    logic [31:0] be;
    logic [32:0] r;
    be = sb ? ~b : b;
    r = {1'b0, a} + {1'b0, be} + {32'd0, sb ? ~ci : ci};
    return {(a[31] == be[31]) && (r[31] != a[31]), r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one isolated operand set; entered and left just after a rising edge
  task automatic run(input string tag, input bit w32, input logic [63:0] a, input logic [63:0] b,
                     input logic ci, input logic sb, input logic [63:0] es, input logic ec, input logic eo);
    int lat;
    logic v;
    if (w32) begin
      a32 = a[31:0]; b32 = b[31:0]; cin32 = ci; sub32 = sb; iv32 = 1'b1;
    end else begin
      a64 = a; b64 = b; cin64 = ci; sub64 = sb; iv64 = 1'b1;
    end
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    lat = 1;
    v = w32 ? ov32 : ov64;
    while (!v && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      v = w32 ? ov32 : ov64;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " sum"}, w32 ? {32'd0, s32} : s64, es);
    chk({tag, " c_out"}, 64'(w32 ? c32 : c64), 64'(ec));
    chk({tag, " overflow"}, 64'(w32 ? o32 : o64), 64'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iv64 = 0; or64 = 1; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0;
    iv32 = 0; or32 = 1; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(ov64), 0);
    chk("rst sum", s64, 0);
    chk("rst c_out", 64'(c64), 0);
    chk("rst overflow", 64'(o64), 0);
    chk("rst out_valid32", 64'(ov32), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 64'(ir64), 1);
    chk("post-rst in_ready32", 64'(ir32), 1);
    @(posedge clk); #1;

    run("wrap64", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'd0, 1, 0);
    run("sovf64", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'h8000_0000_0000_0000, 0, 1);
    run("sub64a", 0, 64'd5, 64'd7, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    run("sub64b", 0, 64'd7, 64'd5, 1, 1, 64'd1, 1, 0);
    run("subovf64", 0, 64'h8000_0000_0000_0000, 64'd1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1);
    run("chunkcarry64", 0, 64'h0000_0000_0000_FFFF, 64'd0, 1, 0, 64'h0000_0000_0001_0000, 0, 0);

    sent = 0; got = 0; prev = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      iv64 = (sent < 8);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      cin64 = 1'($urandom_range(0, 1)); sub64 = 1'($urandom_range(0, 1));
      or64 = !(cyc >= 5 && cyc <= 9);
      @(negedge clk);
      if (ov64 && !or64) begin
        chk("stall in_ready", 64'(ir64), 0);
        if (prev) begin
          chk("stall sum frozen", s64, held[63:0]);
          chk("stall c_out frozen", 64'(c64), 64'(held[64]));
        end
        held = {o64, c64, s64};
      end
      prev = ov64 && !or64;
      if (ov64 && or64) begin
        e66 = (exq.size() > 0) ? exq.pop_front() : 'x;
        chk("stream sum", s64, e66[63:0]);
        chk("stream c_out", 64'(c64), 64'(e66[64]));
        chk("stream overflow", 64'(o64), 64'(e66[65]));
        got++;
      end
      if (iv64 && ir64) begin
        exq.push_back(m64(a64, b64, cin64, sub64));
        sent++;
      end
      @(posedge clk); #1;
    end
    iv64 = 0; or64 = 1;
    chk("stream count", 64'(got), 8);
    @(negedge clk);
    chk("stream drained", 64'(ov64), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      iv64 = 1; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    iv64 = 0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush out_valid", 64'(ov64), 0);
      @(posedge clk); #1;
    end
    run("post-flush", 0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0, 0, 64'h2345_6789_ABCD_F001, 0, 0);

    run("wrap32", 1, 64'hFFFF_FFFF, 64'd1, 0, 0, 64'd0, 1, 0);
    run("sovf32", 1, 64'h7FFF_FFFF, 64'd1, 0, 0, 64'h8000_0000, 0, 1);
    run("sub32a", 1, 64'd5, 64'd7, 0, 1, 64'hFFFF_FFFE, 0, 0);
    run("sub32b", 1, 64'd7, 64'd5, 1, 1, 64'd1, 1, 0);

    got = 0;
    for (int i = 0; i < 10040 && got < 10000; i++) begin
      iv32 = (i < 10000);
      a32 = $urandom; b32 = $urandom;
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ov32) begin
        e34 = (q32.size() > 0) ? q32.pop_front() : 'x;
        chk("rnd32 sum", {32'd0, s32}, {32'd0, e34[31:0]});
        chk("rnd32 c_out", 64'(c32), 64'(e34[32]));
        chk("rnd32 overflow", 64'(o32), 64'(e34[33]));
        got++;
      end
      if (iv32 && ir32) q32.push_back(m32(a32, b32, cin32, sub32));
      @(posedge clk); #1;
    end
    iv32 = 0;
    chk("rnd32 count", 64'(got), 10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 64: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 16: bits resolved per pipeline stage.
REQ-003 Derived constant STAGES = WIDTH/CHUNK; WIDTH SHALL be a multiple of CHUNK.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operand set {a, b, c_in, sub} is present.
REQ-008 in_ready  out  1  block accepts the operand set this cycle.
REQ-009 a  in  WIDTH  operand A, unsigned or two's complement.
REQ-010 b  in  WIDTH  operand B.
REQ-011 c_in  in  1  carry-in; acts as borrow-in when sub=1.
REQ-012 sub  in  1  0 = add, 1 = subtract.
REQ-013 out_valid  out  1  result is present.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 sum  out  WIDTH  result.
REQ-016 c_out  out  1  carry-out; equals NOT borrow-out when sub=1.
REQ-017 overflow  out  1  signed two's-complement overflow.

Function
REQ-018 Add mode SHALL compute {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1).
REQ-019 Subtract mode SHALL compute {c_out, sum} = a + ~b + ~c_in, which is a - b - c_in.
REQ-020 overflow SHALL be 1 iff the MSB of a equals the MSB of the effective B operand and differs from the MSB of sum.
- Effective B is b in add mode and ~b in subtract mode.
REQ-021 Stage k (0..STAGES-1) SHALL add chunk k of the operands.
- Carry-in of stage 0 is the effective carry.
- Carry-in of stage k>0 is the registered carry from stage k-1.
- Upper, not-yet-added chunks SHALL be carried forward in skew registers.
REQ-022 An operand set is accepted on a clock edge where in_valid && in_ready.
REQ-023 Without stalls, the result SHALL appear with out_valid=1 exactly STAGES cycles after acceptance.
REQ-024 Throughput SHALL be one operand set per cycle.
REQ-025 A per-stage valid bit SHALL travel with the data.
REQ-026 Stall is defined as out_valid && !out_ready.
- On stall, all pipeline registers, including valid bits, SHALL hold.
- in_ready SHALL equal !stall (combinational).
REQ-027 Bubbles: when a stage holds valid=0 and there is no stall, the stage SHALL accept new data, so that bubbles collapse.
REQ-028 sum, c_out and overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-030 Operand inputs SHALL be ignored when in_valid=0 or in_ready=0.
REQ-031 Simultaneous accept and output on one edge SHALL both complete.
REQ-032 Carry wrap-around: all-ones + 1 SHALL give sum=0 and c_out=1, with no other side effect.

Reset
REQ-033 While rst=1 at a clock edge, all valid bits SHALL clear.
REQ-034 While rst=1, out_valid=0, sum=0, c_out=0 and overflow=0.
REQ-035 Reset mid-operation SHALL discard all in-flight results; nothing issued before reset SHALL ever appear.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-037 The shared package/header SHALL hold the WIDTH and CHUNK defaults, the STAGES derivation, and the opcode constants ADD=0 and SUB=1.
REQ-038 A single sub-module, adder_chunk, SHALL be instantiated STAGES times.
- Inputs: CHUNK-bit x and y, plus cin.
- Outputs: CHUNK-bit s and cout.
- Purely combinational.
REQ-039 Pipeline registers and valid/stall logic SHALL live in pipelined_adder only.

Verification
REQ-040 Default parameters, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, c_in=0, sub=0 -> after 4 cycles sum=0, c_out=1, overflow=0.
REQ-041 a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=64'h8000_0000_0000_0000, overflow=1, c_out=0.
REQ-042 a=5, b=7, c_in=0, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0 (borrow), overflow=0.
- Then a=7, b=5, c_in=1, sub=1 -> sum=1, c_out=1.
REQ-043 Issue 8 back-to-back random sets with out_ready held 0 for cycles 5-9.
- Required: in_ready=0 during the stall, outputs frozen, all 8 results in order and matching a reference model.
REQ-044 Issue 3 sets, then assert rst for 1 cycle with data in flight.
- Required: out_valid=0 afterwards, no stale results, and the next set completes in 4 cycles.
REQ-045 Repeat REQ-040 to REQ-042 with WIDTH=32, CHUNK=8.
- Required: matching results at latency 4, plus a 10k random comparison against a + b + c_in.
